// File: rtl/serializer_arbiter.sv
// -----------------------------------------------------------------------------
// serializer_arbiter
//   Round-robin arbiter that shares one serializer between NUM_REQ word
//   sources. A word is accepted on a valid/ready handshake. It is then issued
//   as a single-cycle write strobe with the word registered alongside it. The
//   arbiter then waits for the serializer's busy window to open and close
//   before it considers the next grant.
//
// Ports
//   i_clk        clock, all logic on the rising edge
//   i_rst_n      asynchronous reset, active low
//   i_req_valid  per-requester word valid
//   i_req_data   requester k word at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready  one-hot accept, high only in IDLE while the serializer is idle
//   o_ser_wen    one-cycle write strobe to the serializer
//   o_ser_data   registered word presented to the serializer
//   i_ser_busy   serializer busy flag
//   o_grant_id   index of the requester owning the current/last word
//   o_active     high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module serializer_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_ser_wen,
    output logic [DATA_WIDTH-1:0]         o_ser_data,
    input  logic                          i_ser_busy,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
    output logic                          o_active
);

    localparam int              ID_W      = $clog2(NUM_REQ);
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t                state_reg;
    logic                  ser_wen_reg;
    logic [DATA_WIDTH-1:0] ser_data_reg;
    logic [ID_W-1:0]       grant_id_reg;
    logic [ID_W-1:0]       last_grant_reg;

    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
    logic [ID_W-1:0]       winner;
    logic                  any_valid;
    logic [ID_W:0]         cand;
    logic                  grant_en;

    // Unpack the flat data bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_word[gi] = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin search. It starts one past the last grant and wraps. The
    // candidate carries one extra bit so the sum can exceed NUM_REQ-1 before
    // it is folded back. This also works when NUM_REQ is not a power of two.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_grant_reg} + (ID_W+1)'(i);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!any_valid && i_req_valid[cand[ID_W-1:0]]) begin
                winner    = cand[ID_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

    // A grant is only offered when the serializer is idle. The serializer has
    // no reset, so it may still be shifting after this block comes out of
    // reset. Ready is also held low while reset is asserted.
    assign grant_en = (state_reg == IDLE) && any_valid && !i_ser_busy && i_rst_n;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign o_req_ready[gi] = grant_en && (winner == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            ser_wen_reg    <= 1'b0;
            ser_data_reg   <= '0;
            grant_id_reg   <= '0;
            last_grant_reg <= LAST_ID;
        end else begin
            case (state_reg)
                IDLE: begin
                    ser_wen_reg <= 1'b0;
                    if (grant_en) begin
                        ser_data_reg   <= req_word[winner];
                        grant_id_reg   <= winner;
                        last_grant_reg <= winner;
                        ser_wen_reg    <= 1'b1;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    ser_wen_reg <= 1'b0;
                    state_reg   <= WAIT_START;
                end
                WAIT_START: begin
                    // No timeout or re-issue. A serializer that never goes
                    // busy parks the arbiter here.
                    ser_wen_reg <= 1'b0;
                    if (i_ser_busy) begin
                        state_reg <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    ser_wen_reg <= 1'b0;
                    if (!i_ser_busy) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    ser_wen_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign o_ser_wen  = ser_wen_reg;
    assign o_ser_data = ser_data_reg;
    assign o_grant_id = grant_id_reg;
    assign o_active   = (state_reg != IDLE);

endmodule

// File: tb/tb_serializer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serializer_arbiter
//   Drives serializer_arbiter with directed and random stimulus. The bench
//   includes a simple serializer model that stays busy for 8 cycles after
//   wen && !busy. A transaction-level reference model predicts ready, the
//   write strobe, the issued word, the owner and the active flag every cycle.
//   One line is printed per issued word.
// -----------------------------------------------------------------------------
module tb_serializer_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          ser_wen;
    logic [DW-1:0] ser_data;
    logic          ser_busy = 1'b0;
    logic [1:0]    grant_id;
    logic          active;

    always #5 clk = ~clk;

    serializer_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_ser_wen   (ser_wen),
        .o_ser_data  (ser_data),
        .i_ser_busy  (ser_busy),
        .o_grant_id  (grant_id),
        .o_active    (active)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Serializer model
    int ser_cnt      = 0;
    bit ser_responds = 1'b1;
    bit wen_seen     = 1'b0;

    // Reference model: a word is "in flight" from its handshake until the
    // serializer has been seen busy and then idle again.
    bit            m_inflight  = 1'b0;
    bit            m_busy_seen = 1'b0;
    int            m_last      = N - 1;
    logic [DW-1:0] m_data      = '0;
    int            m_id        = 0;
    bit            m_wen       = 1'b0;

    // Transaction log of issued words, as seen on the DUT outputs.
    int            log_id[$];
    int            log_cyc[$];
    logic [DW-1:0] log_data[$];
    int            ready_cycles      = 0;
    int            ready_busy_cycles = 0;

    int exp_order[5] = '{0, 1, 2, 3, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cycle);
        end
    endtask

    // First valid requester strictly after 'last', wrapping around.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (last + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_inflight  = 1'b0;
        m_busy_seen = 1'b0;
        m_last      = N - 1;
        m_data      = '0;
        m_id        = 0;
        m_wen       = 1'b0;
    endtask

    task automatic clear_log();
        log_id.delete();
        log_cyc.delete();
        log_data.delete();
        ready_cycles      = 0;
        ready_busy_cycles = 0;
    endtask

    // One clock cycle. At the falling edge the bench steps the serializer
    // model and applies the inputs. It then compares the DUT outputs with the
    // model. After the rising edge it advances the model.
    task automatic run_cycle(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic r);
        logic [N-1:0] exp_ready;
        int w;
        @(negedge clk);
        if (wen_seen && ser_cnt == 0 && ser_responds) ser_cnt = 8;
        else if (ser_cnt > 0) ser_cnt--;
        ser_busy  = (ser_cnt != 0);
        req_valid = v;
        req_data  = d;
        rst_n     = r;
        if (!r) model_reset();
        #1;
        exp_ready = '0;
        if (r && !m_inflight && !ser_busy && v != 0) exp_ready = N'(1 << rr_pick(v, m_last));
        check("ready",    32'(req_ready), 32'(exp_ready));
        check("wen",      32'(ser_wen),   32'(m_wen));
        check("data",     32'(ser_data),  32'(m_data));
        check("grant_id", 32'(grant_id),  32'(m_id));
        check("active",   32'(active),    32'(m_inflight));
        if (req_ready != 0) ready_cycles++;
        if (req_ready != 0 && ser_busy) ready_busy_cycles++;
        wen_seen = ser_wen;
        if (ser_wen) begin
            log_id.push_back(int'(grant_id));
            log_cyc.push_back(cycle);
            log_data.push_back(ser_data);
            $display("txn cycle %0d grant %0d data 0x%02h", cycle, grant_id, ser_data);
        end
        @(posedge clk);
        cycle++;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_wen = 1'b0;
            if (!m_inflight) begin
                if (v != 0 && !ser_busy) begin
                    w           = rr_pick(v, m_last);
                    m_data      = d[w*DW +: DW];
                    m_id        = w;
                    m_last      = w;
                    m_inflight  = 1'b1;
                    m_busy_seen = 1'b0;
                    m_wen       = 1'b1;
                end
            end else if (ser_busy) begin
                m_busy_seen = 1'b1;
            end else if (m_busy_seen) begin
                m_inflight = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) run_cycle('0, '0, 1'b0);
    endtask

    task automatic wait_wen(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                            input int budget, input string tag);
        int n0;
        int k;
        n0 = log_id.size();
        k  = 0;
        while (log_id.size() == n0 && k < budget) begin
            run_cycle(v, d, 1'b1);
            k++;
        end
        check(tag, 32'(log_id.size() > n0), 32'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((m_inflight || ser_cnt != 0) && k < 60) begin
            run_cycle('0, '0, 1'b1);
            k++;
        end
        check("drain_idle", 32'(m_inflight || ser_cnt != 0), 32'd0);
    endtask

    initial begin
        int k;

        // Reset state
        do_reset(3);
        check("rst_ready",  32'(req_ready), 32'd0);
        check("rst_active", 32'(active),    32'd0);

        // Sole requester 1 with 0xA5
        clear_log();
        wait_wen(4'b0010, 32'h0000_A500, 10, "s1_wen_seen");
        if (log_id.size() > 0) begin
            check("s1_id",   32'(log_id[0]),   32'd1);
            check("s1_data", 32'(log_data[0]), 32'hA5);
        end
        check("s1_ready_cycles", 32'(ready_cycles), 32'd1);
        drain();

        // All four valid from reset: order 0,1,2,3,0 every 11 cycles
        do_reset(2);
        clear_log();
        repeat (50) run_cycle(4'hF, 32'h1312_1110, 1'b1);
        check("s2_count", 32'(log_id.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < log_id.size(); i++) begin
            check("s2_order", 32'(log_id[i]),   32'(exp_order[i]));
            check("s2_word",  32'(log_data[i]), 32'(8'h10 + exp_order[i]));
            if (i > 0) check("s2_period", 32'(log_cyc[i] - log_cyc[i-1]), 32'd11);
        end
        drain();

        // Sole requester 2 held continuously
        clear_log();
        repeat (45) run_cycle(4'b0100, {8'h00, 8'h5C, 16'h0000}, 1'b1);
        check("s3_count", 32'(log_id.size() >= 4), 32'd1);
        for (int i = 0; i < log_id.size(); i++) begin
            check("s3_id", 32'(log_id[i]), 32'd2);
            if (i > 0) check("s3_period", 32'(log_cyc[i] - log_cyc[i-1]), 32'd11);
        end
        drain();

        // Reset while waiting for busy to drop
        clear_log();
        wait_wen(4'b0001, 32'($urandom), 20, "s4_wen_seen");
        k = 0;
        while (ser_cnt != 5 && k < 20) begin
            run_cycle('0, '0, 1'b1);
            k++;
        end
        check("s4_reached_busy", 32'(ser_cnt == 5), 32'd1);
        run_cycle(4'hF, 32'h4433_2211, 1'b0);
        check("s4_rst_wen",    32'(ser_wen), 32'd0);
        check("s4_rst_active", 32'(active),  32'd0);
        clear_log();
        wait_wen(4'hF, 32'h4433_2211, 20, "s4_regrant");
        if (log_id.size() > 0) check("s4_first_id", 32'(log_id[0]), 32'd0);
        check("s4_ready_while_busy", 32'(ready_busy_cycles), 32'd0);
        drain();

        // Short pulse from requester 3 during the busy window
        do_reset(1);
        clear_log();
        wait_wen(4'b0001, 32'h0000_00E1, 10, "s5_wen_seen");
        k = 0;
        while (!ser_busy && k < 10) begin
            run_cycle('0, '0, 1'b1);
            k++;
        end
        run_cycle(4'b1000, 32'h3300_0000, 1'b1);
        clear_log();
        wait_wen(4'b0010, 32'h0000_1100, 20, "s5_req1_wen");
        if (log_id.size() > 0) check("s5_first_id", 32'(log_id[0]), 32'd1);
        drain();

        // Random traffic
        repeat (400) run_cycle(N'($urandom_range(0, 15)), 32'($urandom), 1'b1);
        drain();

        // Serializer that never goes busy: one strobe, then parked
        ser_responds = 1'b0;
        clear_log();
        wait_wen(4'b0100, 32'($urandom), 10, "s7_wen_seen");
        ready_cycles = 0;
        repeat (20) run_cycle(4'hF, 32'($urandom), 1'b1);
        check("s7_ready_cycles", 32'(ready_cycles), 32'd0);
        check("s7_wen_count",    32'(log_id.size()), 32'd1);
        check("s7_active",       32'(active),        32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
